// File: rtl/usr_seq_ctrl.sv
// rtl/usr_seq_ctrl.sv - sequencer serialising 4-bit words into a universal shift register
// Left-shift mode and the dir_i port exist only when USR_LEFT_EN is defined.
module usr_seq_ctrl #(
  parameter int HOLD_CYC = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [3:0]       in_data_i,
`ifdef USR_LEFT_EN
  input  logic             dir_i,
`endif
  output logic             in_ready_o,
  output logic [1:0]       sel_o,
  output logic             rdin_o,
  output logic             ldin_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_e             state_q, state_d;
  logic [1:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]         hold_cnt_q, hold_cnt_d;
  logic [3:0]         data_q, data_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               dir_in;

`ifdef USR_LEFT_EN
  assign dir_in = dir_i;
`else
  assign dir_in = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = data_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d    = in_data_i;
          dir_d     = dir_in;
          bit_cnt_d = 2'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // bit counter wraps 3->0, so LATCH starts its own count at zero
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) state_d = LATCH;
      end
      LATCH: begin
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd1) begin
          bit_cnt_d = 2'd0;
          if (HOLD_CYC == 0) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end else begin
            state_d    = HOLD;
            hold_cnt_d = 4'd0;
          end
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 2'd0;
      hold_cnt_q <= 4'd0;
      data_q     <= 4'd0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      data_q     <= data_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Moore decode: serial bits are zero outside their own shift mode
  always_comb begin
    sel_o  = 2'b00;
    rdin_o = 1'b0;
    ldin_o = 1'b0;
    case (state_q)
      SHIFT: begin
        if (dir_q) begin
          sel_o  = 2'b10;
          ldin_o = data_q[~bit_cnt_q];
        end else begin
          sel_o  = 2'b01;
          rdin_o = data_q[bit_cnt_q];
        end
      end
      LATCH:   sel_o = 2'b11;
      default: sel_o = 2'b00;
    endcase
  end

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb/tb_usr_seq_ctrl.sv - scoreboard bench for usr_seq_ctrl (HOLD_CYC=0/CNT_W=8 and HOLD_CYC=2/CNT_W=2)
module tb_usr_seq_ctrl;

`ifdef USR_LEFT_EN
  localparam bit LEFT_OK = 1'b1;
`else
  localparam bit LEFT_OK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic       rdin;
    logic       ldin;
    logic       busy;
    logic       in_ready;
    logic       done;
    logic [7:0] cnt;
    logic       chk_pout;
    logic [3:0] pout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       dir = 1'b0;

  logic [1:0] sel [2];
  logic       rdin [2];
  logic       ldin [2];
  logic       busy [2];
  logic       in_ready [2];
  logic       done [2];
  logic [7:0] wcnt [2];
  logic [7:0] wcnt0;
  logic [1:0] wcnt1;

  int n_cmp = 0;
  int n_fail = 0;

  exp_t q0 [$];
  exp_t q1 [$];
  int   rem  [2] = '{0, 0};
  int   mcnt [2] = '{0, 0};

  logic [3:0] usr_r  [2] = '{4'd0, 4'd0};
  logic [3:0] stg_r  [2] = '{4'd0, 4'd0};
  logic [3:0] pout_r [2] = '{4'd0, 4'd0};

  always #5 clk = ~clk;

  usr_seq_ctrl #(.HOLD_CYC(0), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
`ifdef USR_LEFT_EN
    .dir_i(dir),
`endif
    .in_ready_o(in_ready[0]), .sel_o(sel[0]), .rdin_o(rdin[0]), .ldin_o(ldin[0]),
    .busy_o(busy[0]), .done_o(done[0]), .word_cnt_o(wcnt0)
  );

  usr_seq_ctrl #(.HOLD_CYC(2), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
`ifdef USR_LEFT_EN
    .dir_i(dir),
`endif
    .in_ready_o(in_ready[1]), .sel_o(sel[1]), .rdin_o(rdin[1]), .ldin_o(ldin[1]),
    .busy_o(busy[1]), .done_o(done[1]), .word_cnt_o(wcnt1)
  );

  assign wcnt[0] = wcnt0;
  assign wcnt[1] = {6'd0, wcnt1};

  function automatic int hold_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int mask_of(input int d);
    return (d == 0) ? 255 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic r, input logic l, input logic b,
                              input logic rdy, input logic dn, input int c,
                              input logic cp, input logic [3:0] p);
    exp_t e;
    e.sel = s; e.rdin = r; e.ldin = l; e.busy = b; e.in_ready = rdy; e.done = dn;
    e.cnt = 8'(c); e.chk_pout = cp; e.pout = p;
    return e;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference: a word is 4 shift cycles, 2 latch cycles, HOLD_CYC hold cycles, then a done cycle
  task automatic accept(input int d);
    logic [3:0] w;
    logic       left;
    int         old_c, new_c;
    w     = in_data;
    left  = dir & LEFT_OK;
    old_c = mcnt[d];
    new_c = (old_c + 1) & mask_of(d);
    mcnt[d] = new_c;
    for (int k = 0; k < 4; k++) begin
      if (left) push(d, mk(2'b10, 1'b0, w[3-k], 1'b1, 1'b0, 1'b0, old_c, 1'b0, 4'd0));
      else      push(d, mk(2'b01, w[k], 1'b0, 1'b1, 1'b0, 1'b0, old_c, 1'b0, 4'd0));
    end
    for (int k = 0; k < 2; k++) push(d, mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, old_c, 1'b0, 4'd0));
    for (int k = 0; k < hold_of(d); k++) push(d, mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, old_c, 1'b0, 4'd0));
    push(d, mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, new_c, 1'b1, w));
    rem[d] = 6 + hold_of(d);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      rem  = '{0, 0};
      mcnt = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rem[d] == 0) begin
          if (in_valid) accept(d);
        end else begin
          rem[d] = rem[d] - 1;
        end
      end
    end
  end

  // Downstream universal shift register with a two-stage parallel latch
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      case (sel[d])
        2'b01: usr_r[d] <= {rdin[d], usr_r[d][3:1]};
        2'b10: usr_r[d] <= {usr_r[d][2:0], ldin[d]};
        2'b11: begin
          stg_r[d]  <= usr_r[d];
          pout_r[d] <= stg_r[d];
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t        e;
      logic [14:0] act, expv;
      act = {sel[d], rdin[d], ldin[d], busy[d], in_ready[d], done[d], wcnt[d]};
      if (d == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (d == 1 && q1.size() > 0) e = q1.pop_front();
      else e = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mcnt[d], 1'b0, 4'd0);
      expv = {e.sel, e.rdin, e.ldin, e.busy, e.in_ready, e.done, e.cnt};
      check($sformatf("dut%0d_cycle{sel,rdin,ldin,busy,rdy,done,cnt}", d), 32'(act), 32'(expv));
      if (e.chk_pout) check($sformatf("dut%0d_pout", d), 32'(pout_r[d]), 32'(e.pout));
    end
  end

  task automatic drive(input logic v, input logic [3:0] dat, input logic dr);
    @(negedge clk);
    in_valid = v;
    in_data  = dat;
    dir      = dr;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dut%0d_sel", tag, d), 32'(sel[d]), 32'd0);
      check($sformatf("%s_dut%0d_rdin_ldin", tag, d), 32'({rdin[d], ldin[d]}), 32'd0);
      check($sformatf("%s_dut%0d_busy_done", tag, d), 32'({busy[d], done[d]}), 32'd0);
      check($sformatf("%s_dut%0d_word_cnt", tag, d), 32'(wcnt[d]), 32'd0);
    end
  endtask

  // Assert reset mid-cycle after the given number of falling edges, release on the next one
  task automatic pulse_rst(input int after_negs, input string tag);
    repeat (after_negs) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 4'b1011 right-shifted
    drive(1'b1, 4'b1011, 1'b0);
    drive(1'b0, 4'd0, 1'b0);
    repeat (12) drive(1'b0, 4'd0, 1'b0);

    // in_valid held with 0x3 then 0xC from a cleared counter
    pulse_rst(0, "pre_b2b");
    drive(1'b1, 4'h3, 1'b0);
    repeat (9) drive(1'b1, 4'hC, 1'b0);
    repeat (12) drive(1'b0, 4'd0, 1'b0);

    // 4'b1000 left-shifted (right-shifted without USR_LEFT_EN)
    drive(1'b1, 4'b1000, 1'b1);
    repeat (12) drive(1'b0, 4'd0, 1'b0);

    // reset in the third shift cycle, then a fresh word
    pulse_rst(0, "pre_abort");
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b0, 4'd0, 1'b0);
    pulse_rst(2, "abort");
    drive(1'b1, 4'h9, 1'b0);
    repeat (12) drive(1'b0, 4'd0, 1'b0);

    // random traffic with in_valid toggling while busy
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_rst($urandom_range(0, 3), "rand");
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    repeat (20) drive(1'b0, 4'd0, 1'b0);

    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
